hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage combined RISC-V/ARM core. It keeps its own scoreboard of in-flight destination registers for the E, M and W stages and compares it with the source registers leaving decode. From that it produces the fetch/decode stall, decode/execute flush and execute-stage forwarding selects. It sits beside stage_d and drives its StallD/FlushD inputs, and it honours the ARM multi-cycle LDM/STM request from decode.

---
 rtl/hazard_if.sv | 33 +++
 rtl/hazard_ctrl.sv | 168 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// hazard_if: decode/execute-side signals exchanged with the hazard controller.
// The pipeline drives the decode-stage instruction fields and the redirect
// strobe (master); hazard_ctrl returns stall, flush and forwarding controls
// (slave).
interface hazard_if #(
    parameter int CNTW = 16
);
    logic            armD;
    logic [4:0]      Rs1D;
    logic [4:0]      Rs2D;
    logic [4:0]      RdD;
    logic            RegWriteD;
    logic [1:0]      ResultSrcD;
    logic            StallFD;
    logic            RedirectE;
    logic            StallF;
    logic            StallD;
    logic            FlushD;
    logic            FlushE;
    logic [1:0]      ForwardAE;
    logic [1:0]      ForwardBE;
    logic [CNTW-1:0] StallCnt;

    modport master (
        output armD, Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, StallFD, RedirectE,
        input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, StallCnt
    );

    modport slave (
        input  armD, Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, StallFD, RedirectE,
        output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, StallCnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard controller for the five-stage RISC-V/ARM pipeline.
// Tracks the destination registers of the instructions in E, M and W and
// compares them with the decode-stage sources to produce StallF/StallD,
// FlushD/FlushE, the E-stage forwarding selects and a saturating count of
// stalled decode cycles.
//
// Build option HAZARD_FWD_EN:
//   defined   - M/W results forwarded into E; only load-use stalls decode.
//   undefined - no forwarding (selects tied to 00); any dependency on E or M
//               stalls decode, W is covered by the falling-edge regfile write.
module hazard_ctrl #(
    parameter int CNTW = 16
) (
    input  logic    clk,
    input  logic    rst,
    hazard_if.slave hz
);

    // E-stage scoreboard entry
    logic            vld_p0;
    logic            arm_p0;
    logic            we_p0;
    logic [4:0]      rd_p0;
    // M-stage scoreboard entry
    logic            vld_p1;
    logic            arm_p1;
    logic            we_p1;
    logic [4:0]      rd_p1;
`ifdef HAZARD_FWD_EN
    // Load flag and operand registers of E, and the W-stage entry, only
    // matter when results are forwarded.
    logic            ld_p0;
    logic [4:0]      rs1_p0;
    logic [4:0]      rs2_p0;
    logic            vld_p2;
    logic            arm_p2;
    logic            we_p2;
    logic [4:0]      rd_p2;
`endif

    logic [CNTW-1:0] stall_cnt;
    logic            hit_e;
    logic            data_stall;
    logic            stall_d;
    logic            flush_e;
    logic            advance;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;

    // A scoreboard entry supplies register rs when it is a live write of the
    // same ISA; RISC-V x0 and ARM r15 never produce a data hazard.
    function automatic logic reg_hit(
        input logic       vld,
        input logic       arm,
        input logic       we,
        input logic [4:0] rd,
        input logic [4:0] rs,
        input logic       arm_ref
    );
        logic real_reg;
        real_reg = arm ? (rd != 5'd15) : (rd != 5'd0);
        return vld & we & (rd == rs) & (arm == arm_ref) & real_reg;
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
        return (&c) ? c : c + {{(CNTW-1){1'b0}}, 1'b1};
    endfunction

`ifdef HAZARD_FWD_EN
    // ALUResultM (10) takes priority over ResultW (01) over the regfile (00).
    function automatic logic [1:0] fwd_sel(input logic from_m, input logic from_w);
        return from_m ? 2'b10 : (from_w ? 2'b01 : 2'b00);
    endfunction
`endif

    assign hit_e = reg_hit(vld_p0, arm_p0, we_p0, rd_p0, hz.Rs1D, hz.armD)
                 | reg_hit(vld_p0, arm_p0, we_p0, rd_p0, hz.Rs2D, hz.armD);

`ifdef HAZARD_FWD_EN
    // Load-use stall and M/W forwarding for the operands of the E instruction
    always_comb begin
        data_stall = ld_p0 & hit_e;
        fwd_a = vld_p0 ? fwd_sel(reg_hit(vld_p1, arm_p1, we_p1, rd_p1, rs1_p0, arm_p0),
                                 reg_hit(vld_p2, arm_p2, we_p2, rd_p2, rs1_p0, arm_p0))
                       : 2'b00;
        fwd_b = vld_p0 ? fwd_sel(reg_hit(vld_p1, arm_p1, we_p1, rd_p1, rs2_p0, arm_p0),
                                 reg_hit(vld_p2, arm_p2, we_p2, rd_p2, rs2_p0, arm_p0))
                       : 2'b00;
    end
`else
    logic hit_m;

    assign hit_m = reg_hit(vld_p1, arm_p1, we_p1, rd_p1, hz.Rs1D, hz.armD)
                 | reg_hit(vld_p1, arm_p1, we_p1, rd_p1, hz.Rs2D, hz.armD);

    // Without forwarding, a dependency on E or M waits until the producer reaches W
    always_comb begin
        data_stall = hit_e | hit_m;
        fwd_a      = 2'b00;
        fwd_b      = 2'b00;
    end
`endif

    // A redirect flushes D, so it overrides any stall of the D instruction
    always_comb begin
        stall_d = data_stall & ~hz.RedirectE;
`ifdef HAZARD_FWD_EN
        flush_e = hz.RedirectE | data_stall;
`else
        flush_e = hz.RedirectE | stall_d;
`endif
        advance = ~stall_d & ~flush_e;
    end

    assign hz.StallD    = stall_d;
    assign hz.StallF    = stall_d | (hz.StallFD & ~hz.RedirectE);
    assign hz.FlushD    = hz.RedirectE;
    assign hz.FlushE    = flush_e;
    assign hz.ForwardAE = fwd_a;
    assign hz.ForwardBE = fwd_b;
    assign hz.StallCnt  = stall_cnt;

    // Control state: scoreboard valid bits and the stall-cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
`ifdef HAZARD_FWD_EN
            vld_p2    <= 1'b0;
`endif
            stall_cnt <= '0;
        end else begin
            vld_p0    <= advance;
            vld_p1    <= vld_p0;
`ifdef HAZARD_FWD_EN
            vld_p2    <= vld_p1;
`endif
            if (stall_d) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
        end
    end

    // Scoreboard payload; loaded every cycle, a bubble is marked by its valid bit alone
    always_ff @(posedge clk) begin
        // D -> E
        arm_p0 <= hz.armD;
        we_p0  <= hz.RegWriteD;
        rd_p0  <= hz.RdD;
`ifdef HAZARD_FWD_EN
        ld_p0  <= hz.ResultSrcD[0];
        rs1_p0 <= hz.Rs1D;
        rs2_p0 <= hz.Rs2D;
`endif
        // E -> M
        arm_p1 <= arm_p0;
        we_p1  <= we_p0;
        rd_p1  <= rd_p0;
`ifdef HAZARD_FWD_EN
        // M -> W
        arm_p2 <= arm_p1;
        we_p2  <= we_p1;
        rd_p2  <= rd_p1;
`endif
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: self-checking bench for hazard_ctrl. A reference model keeps
// the in-flight instructions as a queue (E, M, W) and derives every expected
// output from the nearest older writer of each source register.
`timescale 1ns/1ps
module tb_hazard_ctrl;
    localparam int CNTW = 6;
    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
    localparam int VW = 8 + CNTW;
    localparam logic [VW-1:0] FMASK = {4'b0000, 4'b1111, {CNTW{1'b0}}};
`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        bit       vld;
        bit       arm;
        bit [4:0] rd;
        bit       we;
        bit       ld;
        bit [4:0] rs1;
        bit [4:0] rs2;
    } ent_t;

    typedef struct {
        bit       arm;
        bit [4:0] rs1;
        bit [4:0] rs2;
        bit [4:0] rd;
        bit       we;
        bit       ld;
    } ins_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_if #(.CNTW(CNTW)) hz();
    hazard_ctrl #(.CNTW(CNTW)) dut (.clk(clk), .rst(rst), .hz(hz));

    int checks = 0;
    int errors = 0;

    ent_t pipe[$];   // [0]=E, [1]=M, [2]=W
    ins_t prog[$];
    ins_t cur;
    logic [CNTW-1:0] cnt_m = '0;
    bit exp_sf, exp_sd, exp_fd, exp_fe, fwd_care;
    bit [1:0] exp_fa, exp_fb;

    function automatic ins_t mk(bit arm, bit [4:0] rs1, bit [4:0] rs2, bit [4:0] rd, bit we, bit ld);
        ins_t i;
        i.arm = arm; i.rs1 = rs1; i.rs2 = rs2; i.rd = rd; i.we = we; i.ld = ld;
        return i;
    endfunction

    function automatic ent_t bubble();
        ent_t e;
        e.vld = 0; e.arm = 0; e.rd = 0; e.we = 0; e.ld = 0; e.rs1 = 0; e.rs2 = 0;
        return e;
    endfunction

    // Distance (from stage 'from') to the youngest older writer of r, or -1.
    function automatic int nearest(bit arm, bit [4:0] r, int from);
        for (int i = from; i < 3; i++) begin
            if (pipe[i].vld && pipe[i].we && pipe[i].arm == arm && pipe[i].rd == r &&
                !(arm ? (r == 5'd15) : (r == 5'd0)))
                return i - from;
        end
        return -1;
    endfunction

    function automatic bit [1:0] fsel(int n);
        return (n == 0) ? 2'b10 : ((n == 1) ? 2'b01 : 2'b00);
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {hz.StallF, hz.StallD, hz.FlushD, hz.FlushE, hz.ForwardAE, hz.ForwardBE, hz.StallCnt};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {exp_sf, exp_sd, exp_fd, exp_fe, exp_fa, exp_fb, cnt_m};
    endfunction

    function automatic logic [VW-1:0] msk();
        return fwd_care ? {VW{1'b1}} : ~FMASK;
    endfunction

    // Drive one decode-stage instruction and compute the expected outputs.
    task automatic apply(input ins_t i, input bit sfd, input bit red);
        int n1, n2, rb;
        bit hit_e, hit_em, ds;
        rb = $urandom_range(0, 1);
        hz.armD = i.arm; hz.Rs1D = i.rs1; hz.Rs2D = i.rs2; hz.RdD = i.rd;
        hz.RegWriteD = i.we; hz.ResultSrcD = {rb[0], i.ld};
        hz.StallFD = sfd; hz.RedirectE = red;
        cur = i;
        #1;
        n1 = nearest(i.arm, i.rs1, 0);
        n2 = nearest(i.arm, i.rs2, 0);
        hit_e  = (n1 == 0) || (n2 == 0);
        hit_em = (n1 == 0) || (n1 == 1) || (n2 == 0) || (n2 == 1);
        ds = FWD ? (hit_e && pipe[0].ld) : hit_em;
        exp_sd = ds && !red;
        exp_fd = red;
        exp_fe = red || ds;
        exp_sf = exp_sd || (sfd && !red);
        fwd_care = !FWD || pipe[0].vld;
        exp_fa = 2'b00;
        exp_fb = 2'b00;
        if (FWD && pipe[0].vld) begin
            exp_fa = fsel(nearest(pipe[0].arm, pipe[0].rs1, 1));
            exp_fb = fsel(nearest(pipe[0].arm, pipe[0].rs2, 1));
        end
    endtask

    task automatic feed();
        if (prog.size() > 0) apply(prog[0], 1'b0, 1'b0);
        else apply(mk(0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    endtask

    // Clock edge: advance the model the way the pipeline advances.
    task automatic tick();
        ent_t e;
        @(posedge clk);
        if (rst) begin
            pipe.delete();
            repeat (3) pipe.push_back(bubble());
            cnt_m = '0;
        end else begin
            if (exp_sd && cnt_m != CNT_MAX) cnt_m = cnt_m + 1'b1;
            e = bubble();
            if (!exp_sd && !exp_fe) begin
                e.vld = 1; e.arm = cur.arm; e.rd = cur.rd; e.we = cur.we;
                e.ld = cur.ld; e.rs1 = cur.rs1; e.rs2 = cur.rs2;
            end
            pipe.push_front(e);
            void'(pipe.pop_back());
            if (!exp_sd && prog.size() > 0) void'(prog.pop_front());
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        apply(mk(0, 3, 4, 5, 1, 1), 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        apply(mk(0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
        checks++;
        if (obs_vec() !== '0) begin
            errors++; $display("FAIL reset_outputs: got %b required %b", obs_vec(), {VW{1'b0}});
        end
        checks++;
        if ((obs_vec() & msk()) !== (exp_vec() & msk())) begin
            errors++; $display("FAIL reset_model: got %b required %b", obs_vec(), exp_vec());
        end
        tick();
    endtask

    task automatic test_forward();
        int stalls = 0;
        bit saw10 = 0, saw01 = 0;
        prog = '{mk(0, 1, 2, 5, 1, 0), mk(0, 5, 1, 6, 1, 0), mk(0, 5, 3, 9, 1, 0)};
        for (int c = 0; c < 8; c++) begin
            feed();
            checks++;
            if ((obs_vec() & msk()) !== (exp_vec() & msk())) begin
                errors++; $display("FAIL forward c%0d: got %b required %b", c, obs_vec(), exp_vec());
            end
            stalls += int'(hz.StallD);
            if (fwd_care && hz.ForwardAE == 2'b10) saw10 = 1;
            if (fwd_care && hz.ForwardAE == 2'b01) saw01 = 1;
            tick();
        end
        checks++;
        if (stalls != (FWD ? 0 : 2)) begin
            errors++; $display("FAIL forward_stalls: got %0d required %0d", stalls, FWD ? 0 : 2);
        end
        checks++;
        if ({saw10, saw01} != {FWD, FWD}) begin
            errors++; $display("FAIL forward_selects: got %b required %b", {saw10, saw01}, {FWD, FWD});
        end
    endtask

    task automatic test_load_use();
        int stalls = 0;
        bit saw01 = 0;
        logic [CNTW-1:0] c0, delta;
        c0 = hz.StallCnt;
        prog = '{mk(0, 1, 1, 7, 1, 1), mk(0, 7, 7, 8, 1, 0)};
        for (int c = 0; c < 8; c++) begin
            feed();
            checks++;
            if ((obs_vec() & msk()) !== (exp_vec() & msk())) begin
                errors++; $display("FAIL load_use c%0d: got %b required %b", c, obs_vec(), exp_vec());
            end
            stalls += int'(hz.StallD);
            if (fwd_care && hz.ForwardAE == 2'b01 && hz.ForwardBE == 2'b01) saw01 = 1;
            tick();
        end
        delta = hz.StallCnt - c0;
        checks++;
        if (stalls != (FWD ? 1 : 2)) begin
            errors++; $display("FAIL load_use_stalls: got %0d required %0d", stalls, FWD ? 1 : 2);
        end
        checks++;
        if (int'(delta) != (FWD ? 1 : 2)) begin
            errors++; $display("FAIL load_use_cnt: got %0d required %0d", delta, FWD ? 1 : 2);
        end
        checks++;
        if (saw01 != FWD) begin
            errors++; $display("FAIL load_use_fwd01: got %b required %b", saw01, FWD);
        end
    endtask

    task automatic test_back_to_back();
        int stalls = 0;
        prog = '{mk(0, 1, 1, 7, 1, 1), mk(0, 7, 0, 8, 1, 1), mk(0, 8, 8, 9, 1, 0)};
        for (int c = 0; c < 11; c++) begin
            feed();
            checks++;
            if ((obs_vec() & msk()) !== (exp_vec() & msk())) begin
                errors++; $display("FAIL back_to_back c%0d: got %b required %b", c, obs_vec(), exp_vec());
            end
            stalls += int'(hz.StallD);
            tick();
        end
        checks++;
        if (stalls != (FWD ? 2 : 4)) begin
            errors++; $display("FAIL back_to_back_stalls: got %0d required %0d", stalls, FWD ? 2 : 4);
        end
    endtask

    task automatic test_x0_r0();
        int stalls = 0;
        bit saw10 = 0;
        prog = '{mk(0, 10, 11, 0, 1, 0), mk(0, 0, 0, 3, 1, 0),
                 mk(1, 10, 11, 0, 1, 0), mk(1, 0, 12, 1, 1, 0),
                 mk(1, 10, 11, 15, 1, 0), mk(1, 15, 15, 2, 1, 0),
                 mk(0, 10, 11, 4, 1, 0), mk(1, 4, 4, 6, 1, 0)};
        for (int c = 0; c < 14; c++) begin
            feed();
            checks++;
            if ((obs_vec() & msk()) !== (exp_vec() & msk())) begin
                errors++; $display("FAIL x0_r0 c%0d: got %b required %b", c, obs_vec(), exp_vec());
            end
            stalls += int'(hz.StallD);
            if (fwd_care && hz.ForwardAE == 2'b10) saw10 = 1;
            tick();
        end
        checks++;
        if (stalls != (FWD ? 0 : 2)) begin
            errors++; $display("FAIL x0_r0_stalls: got %0d required %0d", stalls, FWD ? 0 : 2);
        end
        checks++;
        if (saw10 != FWD) begin
            errors++; $display("FAIL r0_fwd10: got %b required %b", saw10, FWD);
        end
    endtask

    task automatic test_redirect();
        apply(mk(0, 1, 1, 7, 1, 1), 1'b0, 1'b0);
        checks++;
        if ((obs_vec() & msk()) !== (exp_vec() & msk())) begin
            errors++; $display("FAIL redirect_pre: got %b required %b", obs_vec(), exp_vec());
        end
        tick();
        apply(mk(0, 7, 7, 8, 1, 1), 1'b0, 1'b1);
        checks++;
        if ({hz.StallD, hz.FlushD, hz.FlushE} !== 3'b011) begin
            errors++; $display("FAIL redirect_flush: got %b required 011", {hz.StallD, hz.FlushD, hz.FlushE});
        end
        checks++;
        if ((obs_vec() & msk()) !== (exp_vec() & msk())) begin
            errors++; $display("FAIL redirect_model: got %b required %b", obs_vec(), exp_vec());
        end
        tick();
        apply(mk(0, 8, 8, 9, 1, 0), 1'b0, 1'b0);
        checks++;
        if (hz.StallD !== 1'b0) begin
            errors++; $display("FAIL redirect_bubble: got StallD=%b required 0", hz.StallD);
        end
        tick();
        for (int c = 0; c < 3; c++) begin
            feed();
            checks++;
            if ((obs_vec() & msk()) !== (exp_vec() & msk())) begin
                errors++; $display("FAIL redirect_drain c%0d: got %b required %b", c, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_ldm_reset();
        bit [2:0] sd_req;
        sd_req = FWD ? 3'b010 : 3'b011;
        feed();
        tick();
        for (int c = 0; c < 3; c++) begin
            if (c == 0) apply(mk(1, 10, 11, 7, 1, 1), 1'b1, 1'b0);
            else apply(mk(1, 7, 12, 8, 1, 1), 1'b1, 1'b0);
            checks++;
            if (hz.StallF !== 1'b1) begin
                errors++; $display("FAIL ldm_stallf c%0d: got %b required 1", c, hz.StallF);
            end
            checks++;
            if (hz.StallD !== sd_req[2-c]) begin
                errors++; $display("FAIL ldm_stalld c%0d: got %b required %b", c, hz.StallD, sd_req[2-c]);
            end
            checks++;
            if ((obs_vec() & msk()) !== (exp_vec() & msk())) begin
                errors++; $display("FAIL ldm_model c%0d: got %b required %b", c, obs_vec(), exp_vec());
            end
            tick();
        end
        apply(mk(1, 10, 11, 7, 1, 1), 1'b1, 1'b0);
        tick();
        rst = 1'b1;
        apply(mk(1, 7, 12, 8, 1, 1), 1'b1, 1'b0);
        checks++;
        if (hz.StallD !== 1'b1) begin
            errors++; $display("FAIL ldm_prereset: got StallD=%b required 1", hz.StallD);
        end
        tick();
        rst = 1'b0;
        apply(mk(1, 7, 12, 8, 1, 1), 1'b0, 1'b0);
        checks++;
        if (obs_vec() !== '0) begin
            errors++; $display("FAIL ldm_postreset: got %b required %b", obs_vec(), {VW{1'b0}});
        end
        tick();
    endtask

    function automatic bit [4:0] rreg();
        case ($urandom_range(0, 4))
            0: return 5'd0;
            1: return 5'd1;
            2: return 5'd2;
            3: return 5'd15;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    task automatic test_random();
        ins_t i;
        bit sfd, red;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            i = mk(1'($urandom_range(0, 1)), rreg(), rreg(), rreg(),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            sfd = ($urandom_range(0, 3) == 0);
            red = ($urandom_range(0, 7) == 0);
            apply(i, sfd, red);
            checks++;
            if ((obs_vec() & msk()) !== (exp_vec() & msk())) begin
                errors++; $display("FAIL random c%0d: got %b required %b", c, obs_vec(), exp_vec());
            end
            tick();
        end
        rst = 1'b0;
    endtask

    task automatic test_saturation();
        for (int c = 0; c < 160; c++) begin
            apply(mk(0, 7, 0, 7, 1, 1), 1'b0, 1'b0);
            checks++;
            if ((obs_vec() & msk()) !== (exp_vec() & msk())) begin
                errors++; $display("FAIL saturation c%0d: got %b required %b", c, obs_vec(), exp_vec());
            end
            tick();
        end
        checks++;
        if (hz.StallCnt !== CNT_MAX) begin
            errors++; $display("FAIL saturation_hold: got %0d required %0d", hz.StallCnt, CNT_MAX);
        end
    endtask

    initial begin
        repeat (3) pipe.push_back(bubble());
        test_reset();
        test_forward();
        test_load_use();
        test_back_to_back();
        test_x0_r0();
        test_redirect();
        test_ldm_reset();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
